// File: rtl/video_mono_tint_fader_if.sv
// Pixel/control bundle for video_mono_tint_fader: the master drives luma and
// mode controls, the slave returns tinted RGB plus fade status.
interface video_mono_tint_fader_if;
  logic       ce_pix;
  logic       vsync;
  logic [2:0] gfx_mode;
  logic [7:0] luma;
  logic [7:0] R_OUT;
  logic [7:0] G_OUT;
  logic [7:0] B_OUT;
  logic [2:0] active_mode;
  logic       busy;

  modport master (
    output ce_pix, vsync, gfx_mode, luma,
    input  R_OUT, G_OUT, B_OUT, active_mode, busy
  );

  modport slave (
    input  ce_pix, vsync, gfx_mode, luma,
    output R_OUT, G_OUT, B_OUT, active_mode, busy
  );
endinterface

// File: rtl/video_mono_tint_fader.sv
// Monochrome-to-tinted-RGB converter with a frame-paced fade between tints.
// Define MONO_FADE_EN to build the fade FSM; otherwise tints switch on the next vsync.
module video_mono_tint_fader #(
  parameter int unsigned STEP_FRAMES = 2
) (
  input  logic                   clk_vid,
  input  logic                   reset_n,
  video_mono_tint_fader_if.slave vif
);

  localparam int         CH_R     = 2;
  localparam int         CH_G     = 1;
  localparam int         CH_B     = 0;
  localparam logic [4:0] LVL_FULL = 5'd16;

  logic            vsync_q;
  logic            frame_tick;
  logic [2:0]      active_mode_q;
  logic [2:0]      active_mode_d;
  logic [4:0]      lvl;
  logic            busy;
  logic [7:0]      luma_half;
  logic [7:0]      luma_f8;
  logic [7:0]      luma_f15;
  logic [2:0][7:0] tint_d;
  logic [2:0][7:0] tint_q;
  logic [2:0][7:0] scaled;
  logic [2:0][7:0] pix_q;

  // An out-of-range STEP_FRAMES shows up as this marker in the elaborated hierarchy.
  if (STEP_FRAMES == 0 || STEP_FRAMES > 15) begin : g_step_frames_illegal
  end

  always_ff @(posedge clk_vid or negedge reset_n) begin
    if (!reset_n) begin
      vsync_q <= 1'b0;
    end else begin
      vsync_q <= vif.vsync;
    end
  end

  assign frame_tick = vif.vsync & ~vsync_q;

  always_ff @(posedge clk_vid or negedge reset_n) begin
    if (!reset_n) begin
      active_mode_q <= 3'b000;
    end else begin
      active_mode_q <= active_mode_d;
    end
  end

  // Floors keep dark pixels visibly tinted instead of collapsing to black.
  assign luma_half = {1'b0, vif.luma[7:1]};
  assign luma_f8   = (vif.luma < 8'h08) ? 8'h08 : vif.luma;
  assign luma_f15  = (vif.luma < 8'h0F) ? 8'h0F : vif.luma;

  always_comb begin
    tint_d = {vif.luma, vif.luma, vif.luma};
    case (active_mode_q)
      3'b001:  tint_d = {8'h00,     luma_f15,  8'h01};
      3'b010:  tint_d = {luma_f8,   luma_half, 8'h01};
      3'b100:  tint_d = {luma_f8,   8'h00,     8'h01};
      3'b101:  tint_d = {8'h00,     luma_half, luma_f8};
      3'b110:  tint_d = {luma_f8,   8'h00,     luma_half};
      3'b111:  tint_d = {luma_half, 8'h00,     luma_f8};
      default: tint_d = {vif.luma,  vif.luma,  vif.luma};
    endcase
  end

  // lvl tops out at 16, so 255*16 still fits in 12 bits and >>4 returns c unchanged.
  for (genvar gi = 0; gi < 3; gi++) begin : g_scale
    logic [11:0] product;
    assign product    = 12'(tint_q[gi]) * 12'(lvl);
    assign scaled[gi] = 8'(product >> 4);
  end

  always_ff @(posedge clk_vid or negedge reset_n) begin
    if (!reset_n) begin
      tint_q <= '0;
      pix_q  <= '0;
    end else if (vif.ce_pix) begin
      tint_q <= tint_d;
      pix_q  <= scaled;
    end
  end

  assign vif.R_OUT       = pix_q[CH_R];
  assign vif.G_OUT       = pix_q[CH_G];
  assign vif.B_OUT       = pix_q[CH_B];
  assign vif.active_mode = active_mode_q;
  assign vif.busy        = busy;

`ifdef MONO_FADE_EN
  typedef enum logic [1:0] {
    IDLE,
    FADE_OUT,
    SWITCH,
    FADE_IN
  } state_t;

  localparam logic [3:0] STEP_CNT = 4'(STEP_FRAMES);

  state_t     state_q;
  state_t     state_d;
  logic [4:0] lvl_q;
  logic [4:0] lvl_d;
  logic [3:0] frame_cnt_q;
  logic [3:0] frame_cnt_d;
  logic       fade_step;

  always_ff @(posedge clk_vid or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      lvl_q       <= LVL_FULL;
      frame_cnt_q <= 4'd0;
    end else begin
      state_q     <= state_d;
      lvl_q       <= lvl_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Frames are only paced while a fade is in flight; the counter keeps
  // running across a direction reversal.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    fade_step   = 1'b0;
    if (state_q == FADE_OUT || state_q == FADE_IN) begin
      if (frame_tick) begin
        if (frame_cnt_q + 4'd1 == STEP_CNT) begin
          frame_cnt_d = 4'd0;
          fade_step   = 1'b1;
        end else begin
          frame_cnt_d = frame_cnt_q + 4'd1;
        end
      end
    end else begin
      frame_cnt_d = 4'd0;
    end
  end

  // Reversal checks take priority, so a step landing on a reversal is dropped.
  always_comb begin
    state_d       = state_q;
    lvl_d         = lvl_q;
    active_mode_d = active_mode_q;
    case (state_q)
      IDLE: begin
        lvl_d = LVL_FULL;
        if (vif.gfx_mode != active_mode_q) begin
          state_d = FADE_OUT;
        end
      end
      FADE_OUT: begin
        if (vif.gfx_mode == active_mode_q) begin
          state_d = FADE_IN;
        end else if (lvl_q == 5'd0) begin
          state_d = SWITCH;
        end else if (fade_step) begin
          lvl_d = lvl_q - 5'd1;
        end
      end
      SWITCH: begin
        active_mode_d = vif.gfx_mode;
        state_d       = FADE_IN;
      end
      FADE_IN: begin
        if (vif.gfx_mode != active_mode_q) begin
          state_d = FADE_OUT;
        end else if (lvl_q >= LVL_FULL) begin
          state_d = IDLE;
        end else if (fade_step) begin
          lvl_d = lvl_q + 5'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign lvl  = lvl_q;
  assign busy = (state_q != IDLE);
`else
  assign active_mode_d = frame_tick ? vif.gfx_mode : active_mode_q;
  assign lvl           = LVL_FULL;
  assign busy          = 1'b0;
`endif

endmodule

// File: doc/video_mono_tint_fader.md
VIDEO_MONO_TINT_FADER -- requirements
Module: video_mono_tint_fader

Interface
REQ-001 SHALL have parameter STEP_FRAMES, default 2, meaning vsync rising edges per fade-level step (legal 1..15).
REQ-002 SHALL have port clk_vid  in  1  video clock; the block has one clock.
REQ-003 SHALL have port reset_n  in  1  reset, asynchronous and active-low.
REQ-004 SHALL have port ce_pix  in  1  pixel enable; the datapath advances only when high.
REQ-005 SHALL have port vsync  in  1  active-high frame sync, sampled every clk_vid.
REQ-006 SHALL have port gfx_mode  in  3  requested tint: 000/011 grey, 001 green, 010 amber, 100 red, 101 blue, 110 fuchsia, 111 purple.
REQ-007 SHALL have port luma  in  8  monochrome intensity input.
REQ-008 SHALL have ports R_OUT, G_OUT, B_OUT  out  8 each  tinted, faded RGB output.
REQ-009 SHALL have port active_mode  out  3  tint currently applied.
REQ-010 SHALL have port busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-011 SHALL give the datapath a latency of 2 ce_pix strobes: stage 1 registers the tint, stage 2 registers the scaled result. Outputs hold between strobes.
REQ-012 Stage 1 SHALL compute from m=luma, h=m>>1, f8=max(m,0x08), f15=max(m,0x0F) using active_mode:
- grey: (m,m,m)
- green: (0,f15,1)
- amber: (f8,h,1)
- red: (f8,0,1)
- blue: (0,h,f8)
- fuchsia: (f8,0,h)
- purple: (h,0,f8)
REQ-013 Stage 2 SHALL output each channel as (c*lvl)>>4, where lvl is 5 bits in 0..16; lvl=16 SHALL reproduce c exactly, and no overflow is possible.
REQ-014 A frame tick SHALL be a vsync 0->1 transition detected on clk_vid. A 4-bit frame counter SHALL count ticks and, on reaching STEP_FRAMES, SHALL clear and issue one step.
REQ-015 The FSM SHALL have states IDLE, FADE_OUT, SWITCH, FADE_IN. It advances every clk_vid and is independent of ce_pix.
REQ-016 IDLE: lvl=16 and the frame counter is held at 0. When gfx_mode!=active_mode, the FSM SHALL enter FADE_OUT on the next clk.
REQ-017 FADE_OUT: each step SHALL decrement lvl. When lvl reaches 0, the FSM SHALL enter SWITCH. If gfx_mode==active_mode, the FSM SHALL enter FADE_IN with lvl unchanged.
REQ-018 SWITCH: active_mode SHALL load the current gfx_mode and the frame counter SHALL clear. The FSM SHALL enter FADE_IN after exactly one clk.
REQ-019 FADE_IN: each step SHALL increment lvl. When lvl reaches 16, the FSM SHALL enter IDLE. If gfx_mode!=active_mode, the FSM SHALL enter FADE_OUT with lvl unchanged.
REQ-020 A step coinciding with a direction reversal SHALL be discarded.
REQ-021 A gfx_mode change during SWITCH SHALL be caught by the REQ-019 check in the following cycle.
REQ-022 lvl SHALL saturate: it never goes below 0 or above 16.

Reset
REQ-023 While reset_n=0, the block SHALL immediately force:
- R_OUT=G_OUT=B_OUT=0x00
- pipeline registers 0
- active_mode=000
- lvl=16
- state IDLE
- frame counter 0
- vsync edge register 0
- busy=0
REQ-024 Reset mid-fade SHALL abandon the fade without a completing step. After release, normal operation SHALL resume on the first clk_vid edge.

Configuration
REQ-025 With macro MONO_FADE_EN defined, fading SHALL operate as in REQ-013..REQ-022.
REQ-026 Without MONO_FADE_EN:
- lvl SHALL be constant 16, and the FSM and frame counter SHALL be absent.
- busy SHALL be tied 0.
- active_mode SHALL load gfx_mode on each frame tick.
- Latency SHALL remain 2 strobes.

Verification (STEP_FRAMES=2, ce_pix continuously high unless stated)
REQ-027 Reset, gfx_mode=000, luma=0x80 -> after 2 strobes RGB=(0x80,0x80,0x80), busy=0.
REQ-028 Mode 000->010, luma=0x80:
- busy=1 on the next clk.
- After 16 frame ticks, RGB=(0x40,0x40,0x40) at lvl 8.
- After 32 ticks, RGB=0 and active_mode=010.
- After 64 ticks, RGB=(0x80,0x40,0x01) and busy=0.
REQ-029 Mode 001 settled, luma=0x05 -> RGB=(0x00,0x0F,0x01). With luma=0xFF -> RGB=(0x00,0xFF,0x01).
REQ-030 Mode 000->011, gfx_mode reverted to 000 at lvl 10 -> FADE_IN from 10. lvl=16 and busy=0 after 12 ticks. active_mode stays 000 throughout.
REQ-031 reset_n pulsed low at lvl 5 during FADE_OUT -> same clock: RGB=0, busy=0, active_mode=000. After release with gfx_mode=000 -> stays IDLE.
REQ-032 MONO_FADE_EN undefined, mode 000->101, luma=0x80 -> active_mode=101 one clk after the next vsync rise. Two strobes later RGB=(0x00,0x40,0x80). busy stays 0.
